// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between N byte-stream requesters, the round-robin arbiter and
// one uart_tx. The arbiter takes the slave view; the requesters and the
// transmitter together form the master side.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req_rdy;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_fetch;
  logic           tx_data_rdy;
  logic [7:0]     tx_data;
  logic           tx_fetch;
  logic [N-1:0]   grant;
  logic           busy;

  modport master (
    output req_rdy, req_data, req_last, tx_fetch,
    input  req_fetch, tx_data_rdy, tx_data, grant, busy
  );

  modport slave (
    input  req_rdy, req_data, req_last, tx_fetch,
    output req_fetch, tx_data_rdy, tx_data, grant, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N byte-stream requesters.
// A grant is held for a whole frame, cut short by a burst limit or by a
// stall timeout. The granted requester's byte is steered to the transmitter
// and the transmitter's fetch pulse is routed back to that requester only.
module uart_tx_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {ST_IDLE, ST_GRANT} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          last_q, last_d;

  logic [IW-1:0] winner;
  logic [IW-1:0] gidx_next;
  logic [BW-1:0] burst_inc;
  logic [SW-1:0] stall_inc;
  logic [7:0]    req_byte [N];

  for (genvar i = 0; i < N; i++) begin : g_split
    assign req_byte[i] = bus.req_data[8*i +: 8];
  end

  assign burst_inc = burst_q + 1'b1;
  assign stall_inc = stall_q + 1'b1;
  assign gidx_next = (int'(gidx_q) == N - 1) ? '0 : gidx_q + 1'b1;

  // Pick the first ready requester at or after the pointer, wrapping modulo N.
  always_comb begin
    int            sum;
    logic [IW-1:0] cand;
    logic          found;
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    winner = ptr_q;
    found  = 1'b0;
    sum    = 0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr_q) + k;
      if (sum >= N) sum = sum - N;
      cand = IW'(sum);
      if (!found && bus.req_rdy[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Next-state logic and data/fetch steering for the IDLE/GRANT machine.
  always_comb begin
    state_d         = state_q;
    gidx_d          = gidx_q;
    ptr_d           = ptr_q;
    burst_d         = burst_q;
    stall_d         = stall_q;
    // last_q freezes during the fetch-high cycle, so it keeps the flag of
    // the byte the transmitter actually sampled.
    last_d          = bus.tx_fetch ? last_q : bus.req_last[gidx_q];
    bus.grant       = '0;
    bus.req_fetch   = '0;
    bus.tx_data_rdy = 1'b0;
    bus.tx_data     = '0;
    bus.busy        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A stray fetch here (transmitter finishing a pre-reset byte) is dropped.
        if (|bus.req_rdy) begin
          gidx_d  = winner;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        bus.busy               = 1'b1;
        bus.grant[gidx_q]      = 1'b1;
        bus.tx_data_rdy        = bus.req_rdy[gidx_q];
        bus.tx_data            = req_byte[gidx_q];
        bus.req_fetch[gidx_q]  = bus.tx_fetch;

        if (bus.tx_fetch) begin
          // Fetch wins over a coinciding stall: the byte counts, stall clears.
          burst_d = burst_inc;
          stall_d = '0;
          if (last_q || (MAX_BURST != 0 && burst_inc == BW'(MAX_BURST))) begin
            state_d = ST_IDLE;
          end
        end else if (!bus.req_rdy[gidx_q]) begin
          stall_d = stall_inc;
          if (TIMEOUT != 0 && stall_inc == SW'(TIMEOUT)) begin
            state_d = ST_IDLE;
          end
        end else begin
          stall_d = '0;
        end

        if (state_d == ST_IDLE) begin
          ptr_d   = gidx_next;
          burst_d = '0;
          stall_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gidx_q  <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      stall_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      stall_q <= stall_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: the bench plays the requester FIFOs
// and a one-clock-per-bit uart_tx (samples when idle, fetch the next cycle,
// 10 cycles per byte), and checks grant order, routing and release timing.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int TO = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_tx_arbiter_if #(.N(N)) bus ();

  uart_tx_arbiter #(.N(N), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // requester FIFO model
  logic [8:0]   fmem [N][32];
  int           fhead [N];
  int           ftail [N];
  logic [N-1:0] hold;

  // transmitter model and logs
  bit           uart_en;
  int           uart_cnt;
  int           cyc;
  int           log_n;
  logic [7:0]   log_d   [64];
  int           log_src [64];
  int           log_cyc [64];
  int           fetch_cnt [N];
  logic [N-1:0] grant_or;
  int           onehot_err;

  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic push(input int i, input logic [7:0] d, input logic l);
    fmem[i][ftail[i]] = {l, d};
    ftail[i]++;
  endtask

  task automatic drive_reqs();
    logic [N-1:0]   rdy;
    logic [N-1:0]   lst;
    logic [8*N-1:0] dat;
    rdy = '0; lst = '0; dat = '0;
    for (int i = 0; i < N; i++) begin
      if (fhead[i] < ftail[i]) begin
        dat[8*i +: 8] = fmem[i][fhead[i]][7:0];
        lst[i]        = fmem[i][fhead[i]][8];
        rdy[i]        = !hold[i];
      end
    end
    bus.req_rdy  = rdy;
    bus.req_data = dat;
    bus.req_last = lst;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      fhead[i] = 0; ftail[i] = 0; fetch_cnt[i] = 0;
    end
    hold = '0; uart_en = 1'b0; uart_cnt = 0; log_n = 0;
    grant_or = '0; bus.tx_fetch = 1'b0;
    drive_reqs();
  endtask

  // One clock: sample outputs at the falling edge, then update the models
  // just after the rising edge.
  task automatic step();
    logic [N-1:0] f, g;
    logic         rdy;
    logic [7:0]   d;
    @(negedge clk);
    f = bus.req_fetch; g = bus.grant; rdy = bus.tx_data_rdy; d = bus.tx_data;
    grant_or = grant_or | g;
    if ($countones(g) > 1) onehot_err++;
    for (int i = 0; i < N; i++) if (f[i]) fetch_cnt[i]++;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (f[i] && fhead[i] < ftail[i]) fhead[i]++;
    bus.tx_fetch = 1'b0;
    if (uart_en) begin
      if (uart_cnt > 0) uart_cnt--;
      else if (rdy && log_n < 64) begin
        log_d[log_n] = d; log_src[log_n] = idx_of(g); log_cyc[log_n] = cyc;
        log_n++;
        uart_cnt = 9;
        bus.tx_fetch = 1'b1;
      end
    end
    drive_reqs();
  endtask

  task automatic run_frames(input int nbytes, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (log_n >= nbytes && !bus.busy && uart_cnt == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_model();
    push(0, 8'h77, 1'b1);
    drive_reqs();
    bus.tx_fetch = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", bus.grant); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.tx_data_rdy !== 1'b0) $display("FAIL reset_tx_data_rdy: got %b want 0", bus.tx_data_rdy); else n_pass++;
    n_checks++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); else n_pass++;
    n_checks++; if (bus.req_fetch !== 4'b0000) $display("FAIL reset_req_fetch: got %b want 0000", bus.req_fetch); else n_pass++;
    bus.tx_fetch = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    uart_en = 1'b1;
    push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
    drive_reqs();
    step();
    n_checks++; if (bus.grant !== 4'b0100) $display("FAIL single_first_grant: got %b want 0100", bus.grant); else n_pass++;
    n_checks++; if ({bus.tx_data_rdy, bus.tx_data} !== 9'h141) $display("FAIL single_first_data: got %h want 141", {bus.tx_data_rdy, bus.tx_data}); else n_pass++;
    run_frames(3, 80, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL single_done: got %b want 1 (frame did not complete)", ok); else n_pass++;
    n_checks++; if ({log_d[0], log_d[1], log_d[2]} !== 24'h414243) $display("FAIL single_bytes: got %h want 414243", {log_d[0], log_d[1], log_d[2]}); else n_pass++;
    n_checks++; if (grant_or !== 4'b0100) $display("FAIL single_grant_only2: got %b want 0100", grant_or); else n_pass++;
    n_checks++; if (fetch_cnt[2] !== 3) $display("FAIL single_fetch2: got %0d want 3", fetch_cnt[2]); else n_pass++;
    n_checks++; if (fetch_cnt[0] + fetch_cnt[1] + fetch_cnt[3] !== 0) $display("FAIL single_fetch_other: got %0d want 0", fetch_cnt[0] + fetch_cnt[1] + fetch_cnt[3]); else n_pass++;
    n_checks++; if (bus.grant !== 4'b0000) $display("FAIL single_released: got %b want 0000", bus.grant); else n_pass++;
    // pointer now 3: with 0 and 3 both ready, 3 wins
    uart_en = 1'b0;
    push(0, 8'h50, 1'b1); push(3, 8'h53, 1'b1);
    drive_reqs();
    step();
    n_checks++; if (bus.grant !== 4'b1000) $display("FAIL single_pointer3: got %b want 1000", bus.grant); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_src [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_d [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    do_reset();
    uart_en = 1'b1;
    push(0, 8'hA0, 1'b1); push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1);
    push(3, 8'hA3, 1'b1); push(0, 8'hA4, 1'b1);
    drive_reqs();
    run_frames(5, 120, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rr_done: got %b want 1 (frames did not complete)", ok); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (log_src[k] !== exp_src[k]) $display("FAIL rr_order[%0d]: got %0d want %0d", k, log_src[k], exp_src[k]); else n_pass++;
      n_checks++; if (log_d[k] !== exp_d[k]) $display("FAIL rr_byte[%0d]: got %h want %h", k, log_d[k], exp_d[k]); else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (log_cyc[k+1] - log_cyc[k] !== 10) $display("FAIL rr_gap[%0d]: got %0d cycles want 10", k, log_cyc[k+1] - log_cyc[k]); else n_pass++;
    end
  endtask

  task automatic test_burst();
    bit ok;
    int n1_head;
    int n1_tail;
    int bad_seq;
    do_reset();
    uart_en = 1'b1;
    for (int k = 0; k < 20; k++) push(1, 8'h10 + 8'(k), (k == 19));
    push(3, 8'hC3, 1'b1);
    drive_reqs();
    run_frames(21, 400, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL burst_done: got %b want 1 (frames did not complete)", ok); else n_pass++;
    n1_head = 0; n1_tail = 0; bad_seq = 0;
    for (int k = 0; k < 16; k++) begin
      if (log_src[k] == 1) n1_head++;
      if (log_d[k] != 8'h10 + 8'(k)) bad_seq++;
    end
    for (int k = 17; k < 21; k++) begin
      if (log_src[k] == 1) n1_tail++;
      if (log_d[k] != 8'h10 + 8'(k - 1)) bad_seq++;
    end
    n_checks++; if (n1_head !== 16) $display("FAIL burst_first16: got %0d want 16", n1_head); else n_pass++;
    n_checks++; if (log_src[16] !== 3) $display("FAIL burst_rotate_to3: got %0d want 3", log_src[16]); else n_pass++;
    n_checks++; if (log_d[16] !== 8'hC3) $display("FAIL burst_byte3: got %h want c3", log_d[16]); else n_pass++;
    n_checks++; if (n1_tail !== 4) $display("FAIL burst_resume4: got %0d want 4", n1_tail); else n_pass++;
    n_checks++; if (bad_seq !== 0) $display("FAIL burst_sequence: got %0d misordered want 0", bad_seq); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1);
    push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
    drive_reqs();
    step();
    n_checks++; if (bus.grant !== 4'b0001) $display("FAIL stall_grant0: got %b want 0001", bus.grant); else n_pass++;
    bus.tx_fetch = 1'b1;
    step();
    hold[0] = 1'b1; drive_reqs();
    repeat (31) step();
    n_checks++; if (bus.grant !== 4'b0001) $display("FAIL stall_hold31: got %b want 0001", bus.grant); else n_pass++;
    n_checks++; if (bus.tx_data_rdy !== 1'b0) $display("FAIL stall_rdy_low: got %b want 0", bus.tx_data_rdy); else n_pass++;
    step();
    n_checks++; if (bus.grant !== 4'b0000) $display("FAIL stall_release32: got %b want 0000", bus.grant); else n_pass++;
    step();
    n_checks++; if (bus.grant !== 4'b0010) $display("FAIL stall_next_grant: got %b want 0010", bus.grant); else n_pass++;
    // requester 1: stall to 31, reassert, then a full fresh timeout is needed
    bus.tx_fetch = 1'b1;
    step();
    hold[1] = 1'b1; drive_reqs();
    repeat (31) step();
    hold[1] = 1'b0; drive_reqs();
    step();
    n_checks++; if (bus.grant !== 4'b0010) $display("FAIL stall_reassert_keep: got %b want 0010", bus.grant); else n_pass++;
    n_checks++; if (bus.tx_data_rdy !== 1'b1) $display("FAIL stall_reassert_rdy: got %b want 1", bus.tx_data_rdy); else n_pass++;
    hold[1] = 1'b1; drive_reqs();
    repeat (31) step();
    n_checks++; if (bus.grant !== 4'b0010) $display("FAIL stall_counter_cleared: got %b want 0010", bus.grant); else n_pass++;
    step();
    n_checks++; if (bus.grant !== 4'b0000) $display("FAIL stall_second_release: got %b want 0000", bus.grant); else n_pass++;
  endtask

  task automatic test_same_edge();
    // fetch on the would-be 32nd stall edge, byte not last: grant kept
    do_reset();
    push(0, 8'hC0, 1'b0); push(0, 8'hC1, 1'b1); push(1, 8'hD0, 1'b1);
    drive_reqs();
    step();
    hold[0] = 1'b1; drive_reqs();
    repeat (31) step();
    bus.tx_fetch = 1'b1;
    step();
    n_checks++; if (bus.grant !== 4'b0001) $display("FAIL same_edge_keep: got %b want 0001", bus.grant); else n_pass++;
    n_checks++; if (fetch_cnt[0] !== 1) $display("FAIL same_edge_fetch_routed: got %0d want 1", fetch_cnt[0]); else n_pass++;
    repeat (31) step();
    n_checks++; if (bus.grant !== 4'b0001) $display("FAIL same_edge_stall_cleared: got %b want 0001", bus.grant); else n_pass++;
    step();
    n_checks++; if (bus.grant !== 4'b0000) $display("FAIL same_edge_late_timeout: got %b want 0000", bus.grant); else n_pass++;
    // same coincidence with a last byte: released by the frame end
    do_reset();
    push(0, 8'hE0, 1'b1); push(1, 8'hE1, 1'b1);
    drive_reqs();
    step();
    hold[0] = 1'b1; drive_reqs();
    repeat (31) step();
    bus.tx_fetch = 1'b1;
    step();
    n_checks++; if (bus.grant !== 4'b0000) $display("FAIL same_edge_last_release: got %b want 0000", bus.grant); else n_pass++;
    step();
    n_checks++; if (bus.grant !== 4'b0010) $display("FAIL same_edge_next: got %b want 0010", bus.grant); else n_pass++;
  endtask

  task automatic test_reset_mid_byte();
    bit ok;
    do_reset();
    uart_en = 1'b1;
    push(1, 8'h11, 1'b1);
    drive_reqs();
    run_frames(1, 40, ok);
    push(3, 8'h33, 1'b0); push(3, 8'h34, 1'b1);
    drive_reqs();
    for (int n = 0; n < 40 && log_n < 2; n++) step();
    n_checks++; if (log_n !== 2 || log_src[1] !== 3) $display("FAIL midrst_setup: got %0d bytes src %0d want 2 bytes src 3", log_n, log_src[1]); else n_pass++;
    repeat (3) step();
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", bus.busy); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.grant !== 4'b0000) $display("FAIL midrst_grant: got %b want 0000", bus.grant); else n_pass++;
    n_checks++; if (bus.tx_data_rdy !== 1'b0) $display("FAIL midrst_tx_data_rdy: got %b want 0", bus.tx_data_rdy); else n_pass++;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_fetch = 1'b1;
    #1;
    n_checks++; if (bus.req_fetch !== 4'b0000) $display("FAIL midrst_fetch_blocked: got %b want 0000", bus.req_fetch); else n_pass++;
    step();
    n_checks++; if ({bus.busy, bus.grant} !== 5'b00000) $display("FAIL midrst_idle: got %b want 00000", {bus.busy, bus.grant}); else n_pass++;
    // pointer back at 0: requester 1 beats requester 3
    push(1, 8'h61, 1'b1); push(3, 8'h63, 1'b1);
    drive_reqs();
    step();
    n_checks++; if (bus.grant !== 4'b0010) $display("FAIL midrst_pointer0: got %b want 0010", bus.grant); else n_pass++;
  endtask

  initial begin
    bus.req_rdy  = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_fetch = 1'b0;
    cyc = 0;
    onehot_err = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_stall();
    test_same_edge();
    test_reset_mid_byte();
    n_checks++; if (onehot_err !== 0) $display("FAIL grant_onehot: got %0d violations want 0", onehot_err); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
